// File: rtl/data_latch_pkg.sv
// Shared definitions for the CPU data latch: M-cycle state encoding and T-state constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_latch_pkg;

  // M-cycle activity decoded at T1 and held until the end of T4
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // T-state numbering as presented on the Phase output
  localparam logic [1:0] PH_T1 = 2'd0;
  localparam logic [1:0] PH_T2 = 2'd1;
  localparam logic [1:0] PH_T3 = 2'd2;
  localparam logic [1:0] PH_T4 = 2'd3;

endpackage

// File: rtl/data_latch_tstate.sv
// T-state counter: free-running T1..T4 sequence, advancing only when Run is high.
// Latency: Phase updates on the CLK2 rising edge after Run is sampled high.
// Backpressure: Run=0 freezes the count; there is no other stall source.
module tstate_counter
  import data_latch_pkg::*;
(
  input  logic       CLK2,
  input  logic       nRESET,
  input  logic       Run,
  output logic [1:0] Phase
);

  logic [1:0] r_phase;

  // Advance one T-state per enabled edge; the 2-bit width gives the T4->T1 wrap
  always_ff @(posedge CLK2 or negedge nRESET) begin
    if (!nRESET) begin
      r_phase <= PH_T1;
    end else if (Run) begin
      r_phase <= r_phase + 2'd1;
    end
  end

  assign Phase = r_phase;

endmodule

// File: rtl/data_latch.sv
// Data latch between the internal databus and the external data pins, sequenced over T1..T4.
// Latency: request decoded leaving T1; read data on DL in T4; write data on pins in T3/T4.
// Backpressure: Run=0 holds every register and therefore every output.
module data_latch
  import data_latch_pkg::*;
(
  input  logic       CLK2,
  input  logic       nRESET,
  input  logic       Run,
  input  logic       MemRd,
  input  logic       MemWr,
  input  logic [7:0] DL_in,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic [7:0] DL_out,
  output logic       DL_drive,
  output logic [1:0] Phase,
  output logic       Done,
  output logic       Err
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_err_set;
  logic [1:0] w_phase;
  logic [7:0] r_rd_dat;
  logic [7:0] r_wr_dat;
  logic       r_err;
  logic       w_rd_cap;
  logic       w_wr_cap;

  tstate_counter u_tstate (
    .CLK2   (CLK2),
    .nRESET (nRESET),
    .Run    (Run),
    .Phase  (w_phase)
  );

  // State register: only moves on enabled edges so a stall freezes the M-cycle
  always_ff @(posedge CLK2 or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_IDLE;
    end else if (Run) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: requests are only looked at in T1, every cycle ends back in IDLE after T4
  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    case (w_phase)
      PH_T1: begin
        if (MemRd && !MemWr) begin
          w_state_nxt = ST_READ;
        end else if (MemWr && !MemRd) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_err_set   = MemRd && MemWr;
        end
      end
      PH_T4:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = r_state;
    endcase
  end

  // Pins are sampled at the end of T3 so the read data is stable throughout T4
  assign w_rd_cap = Run && (r_state == ST_READ) && (w_phase == PH_T3);
  // Bus operand is taken at the end of T2, ready for the pins to be driven from T3
  assign w_wr_cap = Run && (r_state == ST_WRITE) && (w_phase == PH_T2);

  // Read and write data registers
  always_ff @(posedge CLK2 or negedge nRESET) begin
    if (!nRESET) begin
      r_rd_dat <= 8'h00;
      r_wr_dat <= 8'h00;
    end else begin
      if (w_rd_cap) begin
        r_rd_dat <= D_in;
      end
      if (w_wr_cap) begin
        r_wr_dat <= DL_in;
      end
    end
  end

  // Sticky conflict flag: a simultaneous read+write request in T1 is dropped and remembered
  always_ff @(posedge CLK2 or negedge nRESET) begin
    if (!nRESET) begin
      r_err <= 1'b0;
    end else if (Run && w_err_set) begin
      r_err <= 1'b1;
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally
  assign Phase    = w_phase;
  assign DL_out   = r_rd_dat;
  assign D_out    = r_wr_dat;
  assign DL_drive = (r_state == ST_READ) && (w_phase == PH_T4);
  assign D_oe     = (r_state == ST_WRITE) && ((w_phase == PH_T3) || (w_phase == PH_T4));
  assign Done     = (r_state != ST_IDLE) && (w_phase == PH_T4);
  assign Err      = r_err;

endmodule

// File: tb/tb_data_latch.sv
// Directed bench for data_latch: vector table for read/write/back-to-back/stall-free flow,
// plus hand sequences for conflict, Run stall mid-write and reset mid-write.
// Outputs are sampled 1 time unit after each rising CLK2 edge.
module tb_data_latch;

  logic       CLK2;
  logic       nRESET;
  logic       Run;
  logic       MemRd;
  logic       MemWr;
  logic [7:0] DL_in;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       D_oe;
  logic [7:0] DL_out;
  logic       DL_drive;
  logic [1:0] Phase;
  logic       Done;
  logic       Err;

  int checks;
  int failures;

  data_latch dut (
    .CLK2     (CLK2),
    .nRESET   (nRESET),
    .Run      (Run),
    .MemRd    (MemRd),
    .MemWr    (MemWr),
    .DL_in    (DL_in),
    .D_in     (D_in),
    .D_out    (D_out),
    .D_oe     (D_oe),
    .DL_out   (DL_out),
    .DL_drive (DL_drive),
    .Phase    (Phase),
    .Done     (Done),
    .Err      (Err)
  );

  initial CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;

  typedef struct {
    logic       run;
    logic       rd;
    logic       wr;
    logic [7:0] dl;
    logic [7:0] din;
    logic [1:0] ph;
    logic       oe;
    logic [7:0] dout;
    logic [7:0] dlout;
    logic       drv;
    logic       done;
    logic       err;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic run, input logic rd, input logic wr,
                              input logic [7:0] dl, input logic [7:0] din,
                              input logic [1:0] ph, input logic oe, input logic [7:0] dout,
                              input logic [7:0] dlout, input logic drv, input logic done,
                              input logic err);
    vec_t v;
    v.run = run; v.rd = rd; v.wr = wr; v.dl = dl; v.din = din;
    v.ph = ph; v.oe = oe; v.dout = dout; v.dlout = dlout;
    v.drv = drv; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ph, input logic oe,
                         input logic [7:0] dout, input logic [7:0] dlout, input logic drv,
                         input logic done, input logic err);
    chk({tag, " Phase"},    8'(Phase),    8'(ph));
    chk({tag, " D_oe"},     8'(D_oe),     8'(oe));
    chk({tag, " D_out"},    D_out,        dout);
    chk({tag, " DL_out"},   DL_out,       dlout);
    chk({tag, " DL_drive"}, 8'(DL_drive), 8'(drv));
    chk({tag, " Done"},     8'(Done),     8'(done));
    chk({tag, " Err"},      8'(Err),      8'(err));
  endtask

  task automatic tick();
    @(posedge CLK2);
    #1;
  endtask

  task automatic drive(input logic run, input logic rd, input logic wr,
                       input logic [7:0] dl, input logic [7:0] din);
    Run = run; MemRd = rd; MemWr = wr; DL_in = dl; D_in = din;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRESET = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);

    //          run rd wr dl     din   | ph  oe dout   dlout  drv done err
    // read of 5Ah
    tbl[0]  = mk(1, 1, 0, 8'hFF, 8'h00, 2'd1, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 8'hFF, 8'h99, 2'd2, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 8'hFF, 8'h5A, 2'd3, 0, 8'h00, 8'h5A, 1, 1, 0);
    tbl[3]  = mk(1, 0, 1, 8'hFF, 8'h00, 2'd0, 0, 8'h00, 8'h5A, 0, 0, 0);
    // write of C3h (MemRd in T2 must be ignored)
    tbl[4]  = mk(1, 0, 1, 8'hFF, 8'h00, 2'd1, 0, 8'h00, 8'h5A, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 8'hC3, 8'h00, 2'd2, 1, 8'hC3, 8'h5A, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 8'hFF, 8'h00, 2'd3, 1, 8'hC3, 8'h5A, 0, 1, 0);
    tbl[7]  = mk(1, 0, 0, 8'hFF, 8'h00, 2'd0, 0, 8'hC3, 8'h5A, 0, 0, 0);
    // back-to-back: read 11h then write 22h
    tbl[8]  = mk(1, 1, 0, 8'hFF, 8'h11, 2'd1, 0, 8'hC3, 8'h5A, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 8'hFF, 8'h11, 2'd2, 0, 8'hC3, 8'h5A, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 8'hFF, 8'h11, 2'd3, 0, 8'hC3, 8'h11, 1, 1, 0);
    tbl[11] = mk(1, 0, 0, 8'hFF, 8'h00, 2'd0, 0, 8'hC3, 8'h11, 0, 0, 0);
    tbl[12] = mk(1, 0, 1, 8'hFF, 8'h00, 2'd1, 0, 8'hC3, 8'h11, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 8'h22, 8'h00, 2'd2, 1, 8'h22, 8'h11, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 8'hFF, 8'h00, 2'd3, 1, 8'h22, 8'h11, 0, 1, 0);
    tbl[15] = mk(1, 0, 0, 8'hFF, 8'h00, 2'd0, 0, 8'h22, 8'h11, 0, 0, 0);
    // idle M-cycle with one Run=0 edge in T2
    tbl[16] = mk(1, 0, 0, 8'hFF, 8'h00, 2'd1, 0, 8'h22, 8'h11, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 8'hFF, 8'h00, 2'd1, 0, 8'h22, 8'h11, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 8'hFF, 8'h00, 2'd2, 0, 8'h22, 8'h11, 0, 0, 0);
    tbl[19] = mk(1, 0, 0, 8'hFF, 8'hAA, 2'd3, 0, 8'h22, 8'h11, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 8'hFF, 8'h00, 2'd0, 0, 8'h22, 8'h11, 0, 0, 0);

    // reset state, with clocks running and Run high
    Run = 1'b1;
    repeat (2) tick();
    chk_all("reset", 2'd0, 0, 8'h00, 8'h00, 0, 0, 0);
    @(negedge CLK2);
    nRESET = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].run, tbl[i].rd, tbl[i].wr, tbl[i].dl, tbl[i].din);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ph, tbl[i].oe, tbl[i].dout, tbl[i].dlout,
              tbl[i].drv, tbl[i].done, tbl[i].err);
    end

    // conflict at T1: Err sets and stays through the following three M-cycles
    drive(1, 1, 1, 8'hFF, 8'h00);
    tick();
    chk_all("conflict T2", 2'd1, 0, 8'h22, 8'h11, 0, 0, 1);
    drive(1, 0, 0, 8'hFF, 8'h00);
    for (int t = 2; t <= 16; t++) begin
      tick();
      chk_all($sformatf("conflict t%0d", t), 2'(t % 4), 0, 8'h22, 8'h11, 0, 0, 1);
    end

    // write with Run low for 5 edges during T2: no capture while frozen
    drive(1, 0, 1, 8'hFF, 8'h00);
    tick();
    chk_all("stall T2", 2'd1, 0, 8'h22, 8'h11, 0, 0, 1);
    drive(0, 0, 0, 8'hC3, 8'h00);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk_all($sformatf("stall hold%0d", t), 2'd1, 0, 8'h22, 8'h11, 0, 0, 1);
    end
    drive(1, 0, 0, 8'hC3, 8'h00);
    tick();
    chk_all("stall T3", 2'd2, 1, 8'hC3, 8'h11, 0, 0, 1);
    drive(1, 0, 0, 8'hFF, 8'h00);
    tick();
    chk_all("stall T4", 2'd3, 1, 8'hC3, 8'h11, 0, 1, 1);
    tick();
    chk_all("stall next T1", 2'd0, 0, 8'hC3, 8'h11, 0, 0, 1);

    // reset during T3 of a write: outputs clear immediately, no resume afterwards
    drive(1, 0, 1, 8'hFF, 8'h00);
    tick();
    drive(1, 0, 0, 8'h77, 8'h00);
    tick();
    chk_all("rst-wr T3", 2'd2, 1, 8'h77, 8'h11, 0, 0, 1);
    drive(1, 0, 0, 8'hFF, 8'h00);
    #2;
    nRESET = 1'b0;
    #1;
    chk_all("rst mid", 2'd0, 0, 8'h00, 8'h00, 0, 0, 0);
    @(negedge CLK2);
    nRESET = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk_all($sformatf("post-rst t%0d", t), 2'(t % 4), 0, 8'h00, 8'h00, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
